// File: rtl/flex_cnt_pkg.sv
// rtl/flex_cnt_pkg.sv - shared types for the flex up/down counter
// Contents:
//   cnt_dir_t  : count direction, taken from count_up
//   cnt_mode_t : terminal behaviour, taken from saturate
package flex_cnt_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_t;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_t;

endpackage

// File: rtl/flex_prescaler.sv
// rtl/flex_prescaler.sv - enable prescaler producing one step per prescale_val+1 enabled cycles
// Ports:
//   clk          : system clock, rising edge
//   n_rst        : asynchronous active-low reset
//   clear        : synchronous restart of the prescale count (parent drives clear|load)
//   count_enable : advances the prescale count; 0 freezes it
//   prescale_val : terminal prescale count, sampled every cycle
//   step         : high in the enabled cycle where the prescale count reaches prescale_val
module flex_prescaler #(
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic                     step
);

  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

  logic [PRESCALE_BITS-1:0] pre_cnt;
  logic [PRESCALE_BITS-1:0] pre_cnt_nxt;
  logic                     at_term;

  assign at_term = (pre_cnt == prescale_val);
  // Step is qualified by clear so a clear/load cycle never counts.
  assign step    = count_enable && !clear && at_term;

  always_comb begin
    pre_cnt_nxt = pre_cnt;
    if (clear) begin
      pre_cnt_nxt = '0;
    end else if (count_enable) begin
      // A prescale_val lowered below the current count simply lets the
      // count run on and wrap modulo 2^PRESCALE_BITS; no restart.
      if (at_term) begin
        pre_cnt_nxt = '0;
      end else begin
        pre_cnt_nxt = pre_cnt + PRE_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt_nxt;
    end
  end

endmodule

// File: rtl/flex_updown_counter.sv
// rtl/flex_updown_counter.sv - prescaled up/down counter with wrap/saturate terminal modes
// Ports:
//   clk, n_rst    : rising-edge clock, asynchronous active-low reset
//   clear         : synchronous clear of count, flags and prescaler (highest priority)
//   load/load_val : synchronous parallel load, clears flags and prescaler
//   count_enable  : enables prescaler advance and counting
//   count_up      : 1 up, 0 down
//   saturate      : 1 hold at terminal value, 0 wrap
//   rollover_val  : upper bound of the count range
//   prescale_val  : count steps every prescale_val+1 enabled cycles
//   count_out     : registered count
//   rollover_flag : registered level, count at the terminal value of the last step
//   wrap_pulse    : registered one-cycle pulse following a wrap step
module flex_updown_counter
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     count_up,
  input  logic                     saturate,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  cnt_dir_t                dir;
  cnt_mode_t               mode;
  logic                    step;
  logic [NUM_CNT_BITS-1:0] step_count;
  logic                    step_wrap;
  logic [NUM_CNT_BITS-1:0] term_val;
  logic [NUM_CNT_BITS-1:0] count_nxt;
  logic                    flag_nxt;
  logic                    wrap_nxt;

  assign dir  = cnt_dir_t'(count_up);
  assign mode = cnt_mode_t'(saturate);

  // Load restarts the prescale period just like clear.
  flex_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear | load),
    .count_enable(count_enable),
    .prescale_val(prescale_val),
    .step        (step)
  );

  // Value the count would take if this cycle is a step.
  always_comb begin
    step_count = count_out;
    step_wrap  = 1'b0;
    if (rollover_val == '0) begin
      // Degenerate range: both directions pin at zero and never wrap.
      step_count = '0;
    end else if (dir == DIR_UP) begin
      if (count_out < rollover_val) begin
        step_count = count_out + CNT_ONE;
      end else if (mode == MODE_SAT) begin
        step_count = rollover_val;
      end else begin
        step_count = CNT_ONE;
        step_wrap  = 1'b1;
      end
    end else begin
      if (count_out > rollover_val) begin
        step_count = rollover_val;
      end else if (count_out != '0) begin
        step_count = count_out - CNT_ONE;
      end else if (mode == MODE_SAT) begin
        step_count = '0;
      end else begin
        step_count = rollover_val;
        step_wrap  = 1'b1;
      end
    end
  end

  assign term_val = (dir == DIR_UP) ? rollover_val : '0;

  always_comb begin
    count_nxt = count_out;
    flag_nxt  = rollover_flag;
    wrap_nxt  = 1'b0;
    if (clear) begin
      count_nxt = '0;
      flag_nxt  = 1'b0;
    end else if (load) begin
      count_nxt = load_val;
      flag_nxt  = 1'b0;
    end else if (step) begin
      count_nxt = step_count;
      flag_nxt  = (step_count == term_val);
      wrap_nxt  = step_wrap;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else begin
      count_out     <= count_nxt;
      rollover_flag <= flag_nxt;
      wrap_pulse    <= wrap_nxt;
    end
  end

endmodule

// File: doc/flex_updown_counter.md
Name: flex_updown_counter

Overview:
Next-generation flex counter for timing and bit-period generation in the lab datapaths (e.g. the UART/USB receiver timers).
- Adds a programmable enable prescaler.
- Adds up/down direction, a wrap or saturate terminal mode, and synchronous parallel load.
- Adds a one-cycle wrap pulse alongside the level rollover_flag.
- Fully parametrised in counter and prescaler width.

Parameters:
NUM_CNT_BITS, 4, width of count_out, rollover_val, load_val
PRESCALE_BITS, 4, width of prescale_val and internal prescale counter

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  reset, asynchronous, active-low
clear  input  1  synchronous clear of count, flags, prescaler
load  input  1  synchronous load of load_val into count_out
load_val  input  NUM_CNT_BITS  value loaded when load=1
count_enable  input  1  enables prescaler/count advance
count_up  input  1  1=count up, 0=count down
saturate  input  1  1=hold at terminal value, 0=wrap
rollover_val  input  NUM_CNT_BITS  upper bound of count range
prescale_val  input  PRESCALE_BITS  steps every prescale_val+1 enabled cycles
count_out  output  NUM_CNT_BITS  current count, registered
rollover_flag  output  1  registered level: count_out at terminal value
wrap_pulse  output  1  registered one-cycle pulse after a wrap step

Behaviour:
- Reset (n_rst=0, async):
  - count_out=0, rollover_flag=0, wrap_pulse=0.
  - Prescale counter=0.
- All other updates occur on the rising clk edge.
- Priority: clear > load > count step > hold.
- Clear:
  - count_out=0, rollover_flag=0, wrap_pulse=0, prescale counter=0.
- Load:
  - count_out=load_val, rollover_flag=0, wrap_pulse=0, prescale counter=0.
- Prescaler:
  - On each enabled cycle (count_enable=1, no clear/load): if prescale counter==prescale_val, then step=1 and the counter returns to 0; otherwise the counter increments.
  - prescale_val=0 gives a step on every enabled cycle.
  - count_enable=0 freezes the prescale counter.
- Terminal value T:
  - Up (count_up=1): T=rollover_val.
  - Down (count_up=0): T=0.
- Up step:
  - If count_out<rollover_val: count_out+1.
  - If count_out>=rollover_val: wrap to 1 (saturate=0) or hold at rollover_val (saturate=1). In saturate mode an out-of-range value (>rollover_val) is forced to rollover_val.
- Down step:
  - If count_out>rollover_val: forced to rollover_val.
  - If 0<count_out<=rollover_val: count_out-1.
  - If count_out==0: wrap to rollover_val (saturate=0) or hold 0 (saturate=1).
- rollover_val=0:
  - Up and down steps leave count_out=0.
  - rollover_flag=1 after any step; wrap_pulse never asserts.
- rollover_flag:
  - On a step, set to (next count_out==T).
  - On non-step cycles, holds its value.
- wrap_pulse:
  - 1 for exactly the cycle after a wrap step (up: rollover_val->1; down: 0->rollover_val, rollover_val!=0).
  - 0 on every other cycle, including saturation holds.
- Latency: count_out and flags change one clock after the qualifying step cycle. No combinational input-to-output paths.
- count_up, saturate, rollover_val and prescale_val are sampled every cycle; a change takes effect on the next step with no restart.
- Arithmetic is unsigned, modulo 2^NUM_CNT_BITS. rollover_val=all-ones is legal; up-count reaches all-ones then wraps to 1.
- Reset asserted mid-count returns all state to reset values immediately, independent of clk.

Decomposition:
- Package flex_cnt_pkg:
  - typedef enum logic {DIR_DOWN=1'b0, DIR_UP=1'b1} cnt_dir_t.
  - typedef enum logic {MODE_WRAP=1'b0, MODE_SAT=1'b1} cnt_mode_t.
- Sub-module flex_prescaler (params PRESCALE_BITS):
  - Inputs: clk, n_rst, clear (clear|load from parent), count_enable, prescale_val.
  - Output: step.
- The top contains the next-state logic for count and flags.

Test Plan:
1. Reset then up, wrap, rollover_val=5, prescale_val=0, enable held -> count 1,2,3,4,5,1; rollover_flag=1 only while count=5; wrap_pulse=1 only in the cycle count returns to 1.
2. Down, wrap, rollover_val=3, start 0 -> count 3,2,1,0,3; rollover_flag=1 while count=0; wrap_pulse with the 0->3 transition.
3. Up, saturate, rollover_val=4, 8 enabled cycles -> count stops at 4; rollover_flag stays 1; wrap_pulse never asserts.
4. prescale_val=2, enable held 9 cycles -> count advances every 3rd cycle (1,2,3). Drop enable mid-period for 2 cycles -> period extends by 2.
5. load=1, load_val=9, rollover_val=6, up wrap -> count=9, flags 0. Next step -> 1. Same with clear=1 and load=1 together -> count=0.
6. Assert n_rst low between clock edges at count=3 -> count_out, rollover_flag and wrap_pulse read 0 before the next edge; prescale counter restarts.
